checkout_monitor: RTL and testbench
===================================

Name: checkout_monitor

Overview:
- Downstream consumer of the item marker stage: per item passing the store exit gate, it takes the marker's discount (d) and stolen (s) flags, qualified by a one-cycle valid strobe.
- Keeps saturating tallies of items, discounted items and stolen items.
- Runs an alarm state machine that latches on a stolen item, holds until the guard acknowledges, then enforces a cooldown before accepting items again.

Parameters:
- CNT_W, 8, width of all three tally counters; each saturates at 2**CNT_W-1.
- COOLDOWN, 4, cycles spent in CLEAR after acknowledge; legal range 1..255.
- BLINK_DIV, 8, half-period in cycles of the blinking alarm; used only when ALARM_BLINK_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- item_valid  input  1  one item's d/s are valid this cycle.
- d  input  1  discount flag from the marker stage.
- s  input  1  stolen flag from the marker stage.
- ack  input  1  guard acknowledge, level-sampled.
- ready  output  1  high when an item can be accepted.
- item_count  output  CNT_W  accepted items.
- disc_count  output  CNT_W  accepted items with d=1.
- stolen_count  output  CNT_W  accepted items with s=1.
- alarm  output  1  alarm indicator.
- state  output  2  current FSM state encoding.

Behaviour:
- Reset (reset=0, async): state=IDLE, all counts=0, alarm=0, ready=1, cooldown counter=0. Assert reset mid-alarm or mid-cooldown: return to IDLE immediately, no pending work kept.
- Accept rule: an item is accepted on a rising edge when item_valid=1 and ready=1. ready=1 only in IDLE and is a function of state only, not of item_valid. When ready=0, item_valid is ignored: nothing is counted and nothing is buffered.
- On accept:
  - item_count increments.
  - disc_count increments if d=1.
  - stolen_count increments if s=1.
  - All updates are visible the next cycle, i.e. 1-cycle latency.
  - An item with both d=1 and s=1 increments both counters.
- Saturation: each counter holds at all-ones and never wraps.
- FSM states, in order IDLE=0, ALARM=1, CLEAR=2 (encoding 3 unused; it recovers to IDLE on the next cycle):
  - IDLE: on an accepted item with s=1, go to ALARM. alarm rises in the same edge as the counter update.
  - ALARM: alarm=1; stay while ack=0. On ack=1, go to CLEAR and load the cooldown counter with COOLDOWN-1.
  - CLEAR: alarm=0, ready=0. Decrement each cycle; on the cycle the counter equals 0, go to IDLE. CLEAR therefore lasts exactly COOLDOWN cycles. ack is ignored here.
- ack asserted in IDLE has no effect.
- If ack is held high continuously, ALARM still lasts at least one cycle.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro ALARM_BLINK_EN.
- When defined: in ALARM, alarm toggles every BLINK_DIV cycles. It starts at 1 on entry and is forced to 0 on leaving ALARM. This requires an internal divider counter that resets to 0 on ALARM entry.
- When undefined: alarm is a steady 1 throughout ALARM, and no divider logic is synthesized.
- Counters and FSM timing are identical in both builds.

Decomposition:
- Shared package checkout_pkg holds:
  - state enum type (IDLE, ALARM, CLEAR), 2 bits;
  - default widths and COOLDOWN/BLINK_DIV defaults as constants.
- One sub-module, sat_counter: parameterized width, inputs clk, reset, inc; output count; saturating at all-ones. Instantiated three times.

Test Plan:
- Reset then 5 accepted items with d=1,s=0 -> item_count=5, disc_count=5, stolen_count=0, alarm=0, ready=1 throughout.
- Accepted item with s=1 -> next cycle state=1, alarm=1, ready=0. Further item_valid pulses during ALARM leave item_count unchanged.
- In ALARM, pulse ack=1 for 1 cycle with COOLDOWN=4:
  - state=2 for exactly 4 cycles, then state=0 and ready=1.
  - item_valid pulses during CLEAR are not counted.
- CNT_W=3 with 10 accepted items -> item_count holds at 7.
- Assert reset=0 asynchronously in the middle of CLEAR -> immediately state=0, counts=0, alarm=0, with no clock edge needed.
- With ALARM_BLINK_EN and BLINK_DIV=2, trigger the alarm and hold ack=0 for 8 cycles -> alarm pattern 1,1,0,0,1,1,0,0. After ack, alarm=0.

Source files
------------

// File: rtl/checkout_monitor_pkg.sv
// Shared types and defaults for the checkout monitor.
// Holds the FSM state enum and parameter defaults.
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_COOLDOWN  = 4;
    localparam int DEF_BLINK_DIV = 8;

endpackage

// File: rtl/checkout_monitor_if.sv
// Item/guard bus between the marker stage and the monitor.
// master drives items and ack; slave reports tallies and alarm.
interface checkout_monitor_if #(
    parameter int CNT_W = 8
);
    logic             item_valid;
    logic             d;
    logic             s;
    logic             ack;
    logic             ready;
    logic [CNT_W-1:0] item_count;
    logic [CNT_W-1:0] disc_count;
    logic [CNT_W-1:0] stolen_count;
    logic             alarm;
    logic [1:0]       state;

    modport master (
        output item_valid, d, s, ack,
        input  ready, item_count, disc_count,
        input  stolen_count, alarm, state
    );

    modport slave (
        input  item_valid, d, s, ack,
        output ready, item_count, disc_count,
        output stolen_count, alarm, state
    );
endinterface

// File: rtl/checkout_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones, never wraps.
// Async active-low reset clears it to zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc unless already at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/checkout_monitor.sv
// Checkout monitor: item tallies plus stolen-item alarm FSM.
// Optional ALARM_BLINK_EN makes the alarm blink in ALARM.
module checkout_monitor
    import checkout_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int COOLDOWN  = DEF_COOLDOWN,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic clk,
    input  logic reset,
    checkout_monitor_if.slave bus
);

    localparam logic [7:0] COOL_INIT = 8'(COOLDOWN - 1);

    state_t     state_q, state_d;
    logic [7:0] cool_q, cool_d;
    logic       ready;
    logic       accept;

    assign ready  = (state_q == IDLE);
    assign accept = bus.item_valid & ready;

    sat_counter #(.W(CNT_W)) u_items (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (bus.item_count)
    );

    sat_counter #(.W(CNT_W)) u_disc (
        .clk   (clk),
        .reset (reset),
        .inc   (accept & bus.d),
        .count (bus.disc_count)
    );

    sat_counter #(.W(CNT_W)) u_stolen (
        .clk   (clk),
        .reset (reset),
        .inc   (accept & bus.s),
        .count (bus.stolen_count)
    );

    // state and cooldown registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
        end
    end

    // next state; unused encoding falls back to IDLE
    always_comb begin
        state_d = IDLE;
        cool_d  = cool_q;
        unique case (state_q)
            IDLE: begin
                state_d = (accept && bus.s) ? ALARM : IDLE;
            end
            ALARM: begin
                if (bus.ack) begin
                    state_d = CLEAR;
                    cool_d  = COOL_INIT;
                end else begin
                    state_d = ALARM;
                end
            end
            CLEAR: begin
                if (cool_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                    cool_d  = cool_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALARM_BLINK_EN
    localparam logic [15:0] DIV_LAST = 16'(BLINK_DIV - 1);

    logic        blink_q;
    logic [15:0] div_q;

    // blink phase: restart lit on entry, flip every BLINK_DIV cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_q <= 1'b0;
            div_q   <= '0;
        end else if (state_d == ALARM && state_q != ALARM) begin
            blink_q <= 1'b1;
            div_q   <= '0;
        end else if (state_q == ALARM) begin
            if (div_q == DIV_LAST) begin
                div_q   <= '0;
                blink_q <= ~blink_q;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end else begin
            blink_q <= 1'b0;
        end
    end

    assign bus.alarm = (state_q == ALARM) & blink_q;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_DIV != 0);
    assign bus.alarm    = (state_q == ALARM);
`endif

    assign bus.ready = ready;
    assign bus.state = state_q;

endmodule

// File: tb/tb_checkout_monitor.sv
// Directed self-checking bench for checkout_monitor.
// Blink pattern checks follow ALARM_BLINK_EN.
module tb_checkout_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    checkout_monitor_if #(.CNT_W(8)) bus_a ();
    checkout_monitor_if #(.CNT_W(3)) bus_b ();

    checkout_monitor #(
        .CNT_W(8), .COOLDOWN(4), .BLINK_DIV(2)
    ) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    checkout_monitor #(
        .CNT_W(3), .COOLDOWN(4), .BLINK_DIV(2)
    ) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_blink [8];
`ifdef ALARM_BLINK_EN
        exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_blink = '{1'b1, 1'b1, 1'b1, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b1};
`endif
        bus_a.item_valid = 1'b0;
        bus_a.d = 1'b0;
        bus_a.s = 1'b0;
        bus_a.ack = 1'b0;
        bus_b.item_valid = 1'b0;
        bus_b.d = 1'b0;
        bus_b.s = 1'b0;
        bus_b.ack = 1'b0;

        #3;
        check("rst_state", bus_a.state, 0);
        check("rst_items", bus_a.item_count, 0);
        check("rst_alarm", bus_a.alarm, 0);
        check("rst_ready", bus_a.ready, 1);
        #10;
        rst_n = 1'b1;

        bus_a.item_valid = 1'b1;
        bus_a.d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("disc_ready", bus_a.ready, 1);
            check("disc_alarm", bus_a.alarm, 0);
        end
        bus_a.item_valid = 1'b0;
        bus_a.d = 1'b0;
        check("five_items", bus_a.item_count, 5);
        check("five_disc", bus_a.disc_count, 5);
        check("five_stolen", bus_a.stolen_count, 0);

        bus_a.item_valid = 1'b1;
        bus_a.s = 1'b1;
        tick();
        bus_a.s = 1'b0;
        check("alm_state", bus_a.state, 1);
        check("alm_alarm", bus_a.alarm, 1);
        check("alm_ready", bus_a.ready, 0);
        check("alm_items", bus_a.item_count, 6);
        check("alm_stolen", bus_a.stolen_count, 1);
        check("alm_disc", bus_a.disc_count, 5);
        tick();
        tick();
        bus_a.item_valid = 1'b0;
        check("alm_ignored", bus_a.item_count, 6);

        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
        bus_a.item_valid = 1'b1;
        check("clr_state", bus_a.state, 2);
        check("clr_alarm", bus_a.alarm, 0);
        check("clr_ready", bus_a.ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_hold", bus_a.state, 2);
        end
        tick();
        bus_a.item_valid = 1'b0;
        check("clr_done", bus_a.state, 0);
        check("clr_ready1", bus_a.ready, 1);
        check("clr_items", bus_a.item_count, 6);

        bus_a.item_valid = 1'b1;
        bus_a.d = 1'b1;
        bus_a.s = 1'b1;
        tick();
        bus_a.item_valid = 1'b0;
        bus_a.d = 1'b0;
        bus_a.s = 1'b0;
        check("both_items", bus_a.item_count, 7);
        check("both_disc", bus_a.disc_count, 6);
        check("both_stolen", bus_a.stolen_count, 2);
        check("both_state", bus_a.state, 1);
        bus_a.ack = 1'b1;
        tick();
        check("ackhold_clr", bus_a.state, 2);
        tick();
        check("ack_in_clr", bus_a.state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", bus_a.state, 0);
        check("arst_items", bus_a.item_count, 0);
        check("arst_stolen", bus_a.stolen_count, 0);
        check("arst_alarm", bus_a.alarm, 0);
        check("arst_ready", bus_a.ready, 1);
        bus_a.ack = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst", bus_a.state, 0);

        bus_a.ack = 1'b1;
        tick();
        tick();
        bus_a.ack = 1'b0;
        check("ack_idle", bus_a.state, 0);
        check("ack_idle_rdy", bus_a.ready, 1);

        bus_b.item_valid = 1'b1;
        bus_b.d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        bus_b.item_valid = 1'b0;
        bus_b.d = 1'b0;
        check("sat_items", bus_b.item_count, 7);
        check("sat_disc", bus_b.disc_count, 7);
        check("sat_stolen", bus_b.stolen_count, 0);

        bus_a.item_valid = 1'b1;
        bus_a.s = 1'b1;
        tick();
        bus_a.item_valid = 1'b0;
        bus_a.s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("blink%0d", i),
                  bus_a.alarm, exp_blink[i]);
            tick();
        end
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
        check("blink_off", bus_a.alarm, 0);
        check("blink_clr", bus_a.state, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
